// File: rtl/subckt_activity_sequencer.sv
// subckt_activity_sequencer: walks a small combinational sub-circuit through its whole input space
// and counts output toggles, input bit toggles and output-high vectors.
module subckt_activity_sequencer #(
  parameter int N_IN  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             gray,
  output logic [N_IN-1:0]  vec_o,
  input  logic             resp_i,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] out_toggles,
  output logic [CNT_W-1:0] in_toggles,
  output logic [CNT_W-1:0] ones_count
);
  localparam int SW = CNT_W + 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_DRIVE = 2'd1, S_SAMPLE = 2'd2, S_DONE = 2'd3;
  localparam logic [N_IN:0] LAST = {1'b0, {N_IN{1'b1}}};
  logic [1:0] state;
  logic [N_IN:0] idx;
  logic gmode, prev;
  logic [N_IN-1:0] nv;
  logic [SW-1:0] hd;
  function automatic logic [N_IN-1:0] order(input logic [N_IN-1:0] b, input logic g);
    return g ? b ^ (b >> 1) : b;
  endfunction
  // Increments are widened so a Hamming distance larger than a narrow counter still saturates.
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c, input logic [SW-1:0] inc);
    logic [SW-1:0] s;
    s = SW'(c) + inc;
    return (s > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction
  always_comb begin
    nv = order(idx[N_IN-1:0] + N_IN'(1), gmode);
    hd = SW'($countones(vec_o ^ nv));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      vec_o       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      out_toggles <= '0;
      in_toggles  <= '0;
      ones_count  <= '0;
      idx         <= '0;
      gmode       <= 1'b0;
      prev        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          out_toggles <= '0;
          in_toggles  <= '0;
          ones_count  <= '0;
          gmode       <= gray;
          idx         <= '0;
          vec_o       <= '0;
          busy        <= 1'b1;
          state       <= S_DRIVE;
        end
        S_DRIVE: state <= S_SAMPLE;
        S_SAMPLE: begin
          ones_count <= sat(ones_count, SW'(resp_i));
          if (idx != '0) out_toggles <= sat(out_toggles, SW'(resp_i != prev));
          prev <= resp_i;
          if (idx == LAST) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx        <= idx + (N_IN + 1)'(1);
            vec_o      <= nv;
            in_toggles <= sat(in_toggles, hd);
            state      <= S_DRIVE;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_subckt_activity_sequencer.sv
// tb_subckt_activity_sequencer: random runs against a truth-table reference model with a
// done-driven scoreboard; a second 3-bit-counter instance covers saturation.
module tb_subckt_activity_sequencer;
  logic clk = 0, rst_n = 0, start = 0, gray = 0;
  logic [3:0] vec, vec3;
  logic resp, resp3, busy, done, busy3, done3;
  logic [15:0] ot, it, oc;
  logic [2:0] ot3, it3, oc3;
  bit [15:0] tt, f_tt;
  typedef struct {int o; int i; int n; int o3; int i3; int n3;} res_t;
  res_t q[$];
  res_t fin, r;
  int cyc = 0, k = -1000, checks = 0, errors = 0;
  logic [3:0] lastvec = 0;
  bit mgray, run_on;
  int j;

  assign resp  = tt[vec];
  assign resp3 = tt[vec3];
  always #5 clk = ~clk;

  subckt_activity_sequencer #(.N_IN(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gray(gray), .vec_o(vec), .resp_i(resp),
    .busy(busy), .done(done), .out_toggles(ot), .in_toggles(it), .ones_count(oc));
  subckt_activity_sequencer #(.N_IN(4), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .gray(gray), .vec_o(vec3), .resp_i(resp3),
    .busy(busy3), .done(done3), .out_toggles(ot3), .in_toggles(it3), .ones_count(oc3));

  function automatic logic [3:0] ord(int i, bit g);
    logic [3:0] b;
    b = 4'(i);
    return g ? b ^ (b >> 1) : b;
  endfunction
  function automatic int sat(int v, int m);
    return v > m ? m : v;
  endfunction
  // Counts only grow, so saturating the final totals equals saturating every step.
  function automatic res_t model(bit [15:0] t, bit g);
    res_t m;
    int o = 0, i = 0, n = 0;
    for (int x = 0; x < 16; x++) begin
      n += int'(t[ord(x, g)]);
      if (x > 0) begin
        o += int'(t[ord(x, g)] != t[ord(x - 1, g)]);
        i += $countones(ord(x, g) ^ ord(x - 1, g));
      end
    end
    m.o = sat(o, 65535); m.i = sat(i, 65535); m.n = sat(n, 65535);
    m.o3 = sat(o, 7); m.i3 = sat(i, 7); m.n3 = sat(n, 7);
    return m;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      k = -1000;
      fin = '{default: 0};
      lastvec = 0;
      q.delete();
    end else if (start && cyc >= k + 34) begin
      k = cyc;
      mgray = gray;
      fin = model(tt, gray);
      q.push_back(fin);
      lastvec = ord(15, gray);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_vec", {vec, vec3}, 0);
      chk("rst_flags", {busy, done, busy3, done3}, 0);
      chk("rst_cnt", {ot, it}, 0);
      chk("rst_cnt2", {oc, 7'd0, ot3, it3, oc3}, 0);
    end else begin
      run_on = cyc >= k && cyc <= k + 32;
      j = (cyc - k) / 2;
      chk("busy", {busy, busy3}, {2{run_on}});
      chk("done", {done, done3}, {2{cyc == k + 32}});
      chk("vec", vec, run_on ? ord(j > 15 ? 15 : j, mgray) : lastvec);
      chk("vec3", vec3, vec);
      if (cyc == k || cyc == k + 1) begin
        chk("clr", {ot, it, oc}, 0);
        chk("clr3", {ot3, it3, oc3}, 0);
      end
      if (cyc >= k + 32) begin
        chk("hold_out", ot, fin.o);
        chk("hold_in", it, fin.i);
        chk("hold_ones", oc, fin.n);
        chk("hold3", {ot3, it3, oc3}, {3'(fin.o3), 3'(fin.i3), 3'(fin.n3)});
      end
      if (done) begin
        chk("sb_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          r = q.pop_front();
          chk("sb_out_toggles", ot, r.o);
          chk("sb_in_toggles", it, r.i);
          chk("sb_ones_count", oc, r.n);
          chk("sb_out_toggles3", ot3, r.o3);
          chk("sb_in_toggles3", it3, r.i3);
          chk("sb_ones_count3", oc3, r.n3);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_done();
    int t = 0;
    while (!done && t < 200) begin
      step();
      t++;
    end
    chk("done_timeout", t < 200, 1);
    step();
  endtask
  task automatic run(bit [15:0] t, bit g);
    tt = t;
    gray = g;
    start = 1;
    step();
    start = 0;
    gray = 1'($urandom);
    wait_done();
  endtask

  initial begin
    logic [3:0] v;
    for (int x = 0; x < 16; x++) begin
      v = 4'(x);
      f_tt[x] = v[0] ^ (v[2] & v[3] & (v[0] | v[1]));
    end
    tt = f_tt;
    step();
    step();
    rst_n = 1;
    step();
    run(f_tt, 0);
    run(f_tt, 1);
    run(16'hFFFF, 0);
    tt = f_tt;
    gray = 0;
    start = 1;
    step();
    for (int x = 0; x < 30; x++) begin
      start = 1'($urandom);
      gray = 1'($urandom);
      step();
    end
    start = 0;
    wait_done();
    gray = 0;
    start = 1;
    step();
    start = 0;
    repeat (10) step();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    step();
    run(f_tt, 0);
    gray = 0;
    start = 1;
    step();
    wait_done();
    step();
    start = 0;
    wait_done();
    repeat (6) begin
      repeat ($urandom_range(0, 3)) step();
      run(16'($urandom), 1'($urandom));
    end
    step();
    step();
    chk("pending", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
